// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO write-side engine.
package afifo_pkg;

  // Write-engine FSM states, also exported on the debug state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } afifo_wr_state_e;

  // Raw state constants used by the FSM register.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  // Stall-timer width: enough bits to reach the timeout value, never below 1.
  function automatic int timer_width(input int full_timeout);
    return (full_timeout < 1) ? 1 : $clog2(full_timeout + 1);
  endfunction

endpackage

// File: rtl/afifo_evt_counter.sv
// Wrapping event counter: counts single-cycle inc pulses, clears on sync reset.
module afifo_evt_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Count up on each inc; natural overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/afifo_wr_engine.sv
// Write-side engine for the async FIFO. Holds each accepted word on the
// FIFO write port until it commits (winc && !wfull at an edge) or the
// full-timeout expires and the word is dropped.
//
// Handshake: a request word transfers at a wclk edge where req_valid and
// req_ready are both high; req_valid may be raised at any time and the
// word must be held until that edge, req_ready is combinational and never
// depends on req_valid.
module afifo_wr_engine
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int FULL_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  full_notify,
  output logic                  drop,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output afifo_wr_state_e       state_dbg
);

  localparam int TW = timer_width(FULL_TIMEOUT);
  localparam logic [TW-1:0] TO_VAL = TW'(FULL_TIMEOUT);

  // ADDR_WIDTH only mirrors the FIFO parameter set; the engine never
  // addresses memory, so it is consumed here and nowhere else.
  if (ADDR_WIDTH > 0) begin : g_addr_parity
  end

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          accept;
  logic          timeout_hit;
  logic          wr_inc;
  logic          drop_inc;

  // Request-side ready and the per-cycle event strobes.
  always_comb begin
    req_ready   = (state == ST_IDLE) || ((state == ST_WRITE) && !wfull);
    accept      = req_valid && req_ready;
    timeout_hit = (FULL_TIMEOUT != 0) && (timer == TO_VAL);
    wr_inc      = winc && !wfull;
    drop_inc    = (state == ST_STALL) && wfull && timeout_hit;
    busy        = (state != ST_IDLE);
    state_dbg   = afifo_wr_state_e'(state);
  end

  // FSM, stall timer and registered write-port outputs.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      winc        <= 1'b0;
      wdata       <= '0;
      full_notify <= 1'b0;
      drop        <= 1'b0;
    end else begin
      full_notify <= 1'b0;
      drop        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_WRITE;
            wdata <= req_data;
            winc  <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (!wfull) begin
            // Word commits this edge; chain the next one if offered.
            if (accept) begin
              wdata <= req_data;
            end else begin
              state <= ST_IDLE;
              winc  <= 1'b0;
            end
          end else begin
            state       <= ST_STALL;
            full_notify <= 1'b1;
            timer       <= TW'(1);
          end
        end
        ST_STALL: begin
          if (!wfull) begin
            // Commit wins over a timeout reached in the same cycle.
            state <= ST_IDLE;
            winc  <= 1'b0;
            timer <= '0;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
            winc  <= 1'b0;
            drop  <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          winc  <= 1'b0;
          timer <= '0;
        end
      endcase
    end
  end

  afifo_evt_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk   (wclk),
    .rst   (wrst),
    .inc   (wr_inc),
    .count (wr_count)
  );

  afifo_evt_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (wclk),
    .rst   (wrst),
    .inc   (drop_inc),
    .count (drop_count)
  );

endmodule

// File: tb/tb_afifo_wr_engine.sv
// Bench for afifo_wr_engine: two instances share the stimulus, one with a
// short timeout (4, 16-bit counters) and one waiting forever (0, 4-bit
// counters so wrap is exercised). A word-level reference model predicts
// every output each cycle.
module tb_afifo_wr_engine;
  import afifo_pkg::*;

  localparam int DW = 32;

  // ---------------- clock / reset / inputs ----------------
  logic          wclk = 1'b0;
  logic          wrst = 1'b1;
  logic          req_valid = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic          wfull = 1'b0;

  always #5 wclk = ~wclk;

  // ---------------- DUT outputs ----------------
  logic            rdy [2];
  logic            winc [2];
  logic            busy [2];
  logic            fn [2];
  logic            drp [2];
  logic [DW-1:0]   wd [2];
  logic [15:0]     wc_a, dc_a;
  logic [3:0]      wc_b, dc_b;
  afifo_wr_state_e st [2];

  afifo_wr_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(8), .FULL_TIMEOUT(4), .CNT_WIDTH(16)) u_a (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_data(req_data), .wfull(wfull), .winc(winc[0]), .wdata(wd[0]),
    .busy(busy[0]), .full_notify(fn[0]), .drop(drp[0]),
    .wr_count(wc_a), .drop_count(dc_a), .state_dbg(st[0])
  );

  afifo_wr_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(8), .FULL_TIMEOUT(0), .CNT_WIDTH(4)) u_b (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_data(req_data), .wfull(wfull), .winc(winc[1]), .wdata(wd[1]),
    .busy(busy[1]), .full_notify(fn[1]), .drop(drp[1]),
    .wr_count(wc_b), .drop_count(dc_b), .state_dbg(st[1])
  );

  // ---------------- reference model (word level) ----------------
  int            to_cfg [2] = '{4, 0};
  int            cmask  [2] = '{32'hFFFF, 32'hF};
  bit            m_ok;          // model is meaningful once a reset edge is seen
  bit            m_have [2];    // a word is being held on the write port
  int            m_fs   [2];    // full cycles seen by the held word so far
  logic [DW-1:0] m_wdata [2];
  int            m_wr   [2];
  int            m_dc   [2];
  bit            m_fn   [2];
  bit            m_drop [2];

  int tests = 0;
  int fails = 0;
  int step_no = 0;

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input int i, input bit f);
    return !m_have[i] || (m_fs[i] == 0 && !f);
  endfunction

  function automatic afifo_wr_state_e model_state(input int i);
    if (!m_have[i]) return IDLE;
    if (m_fs[i] == 0) return WRITE;
    return STALL;
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [DW-1:0] d, input bit f);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_have[i] = 0; m_fs[i] = 0; m_wdata[i] = '0;
        m_wr[i] = 0; m_dc[i] = 0; m_fn[i] = 0; m_drop[i] = 0;
      end else begin
        bit acc;
        acc = v && model_ready(i, f);
        m_fn[i] = 0;
        m_drop[i] = 0;
        if (m_have[i]) begin
          if (!f) begin
            m_wr[i]++;
            m_have[i] = 0;
          end else begin
            m_fs[i]++;
            if (m_fs[i] == 1) m_fn[i] = 1;
            if (to_cfg[i] != 0 && m_fs[i] == to_cfg[i] + 1) begin
              m_drop[i] = 1;
              m_dc[i]++;
              m_have[i] = 0;
            end
          end
        end
        if (acc) begin
          m_have[i]  = 1;
          m_fs[i]    = 0;
          m_wdata[i] = d;
        end
      end
    end
    if (r) m_ok = 1;
  endtask

  // ---------------- driver: one cycle ----------------
  task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input bit f);
    logic [31:0] wcv [2];
    logic [31:0] dcv [2];
    @(negedge wclk);
    wrst = r; req_valid = v; req_data = d; wfull = f;
    #1;
    step_no++;
    wcv[0] = 32'(wc_a); wcv[1] = 32'(wc_b);
    dcv[0] = 32'(dc_a); dcv[1] = 32'(dc_b);
    if (m_ok) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d.req_ready@%0d", i, step_no), 32'(rdy[i]), 32'(model_ready(i, f)));
        check($sformatf("u%0d.winc@%0d", i, step_no), 32'(winc[i]), 32'(m_have[i]));
        check($sformatf("u%0d.busy@%0d", i, step_no), 32'(busy[i]), 32'(m_have[i]));
        check($sformatf("u%0d.state@%0d", i, step_no), 32'(st[i]), 32'(model_state(i)));
        check($sformatf("u%0d.wdata@%0d", i, step_no), wd[i], m_wdata[i]);
        check($sformatf("u%0d.full_notify@%0d", i, step_no), 32'(fn[i]), 32'(m_fn[i]));
        check($sformatf("u%0d.drop@%0d", i, step_no), 32'(drp[i]), 32'(m_drop[i]));
        check($sformatf("u%0d.wr_count@%0d", i, step_no), wcv[i], 32'(m_wr[i] & cmask[i]));
        check($sformatf("u%0d.drop_count@%0d", i, step_no), dcv[i], 32'(m_dc[i] & cmask[i]));
      end
    end
    @(posedge wclk);
    model_edge(r, v, d, f);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0);
  endtask

  task automatic full_for(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 1);
  endtask

  // ---------------- directed then random stimulus ----------------
  initial begin
    m_ok = 0;
    for (int i = 0; i < 2; i++) begin
      m_have[i] = 0; m_fs[i] = 0; m_wdata[i] = '0;
      m_wr[i] = 0; m_dc[i] = 0; m_fn[i] = 0; m_drop[i] = 0;
    end

    // reset then idle
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    idle(3);

    // streaming 0x10..0x17
    for (int k = 0; k < 8; k++) step(0, 1, 32'h10 + 32'(k), 0);
    idle(2);

    // full stall then release (shorter than the 4-cycle timeout)
    step(0, 1, 32'hAA, 0);
    full_for(3);
    step(0, 1, 32'h55, 0);   // commit cycle: STALL is not ready, 0x55 is not taken
    idle(2);

    // timeout drop on the short-timeout instance, then a fresh request
    step(0, 1, 32'hBB, 0);
    full_for(5);
    idle(1);
    step(0, 1, 32'hCC, 0);
    idle(2);

    // wfull falls exactly when the timer reaches the timeout
    step(0, 1, 32'hDD, 0);
    full_for(4);
    idle(2);

    // wait-forever instance under a long full period
    step(0, 1, 32'hEE, 0);
    full_for(100);
    idle(2);

    // reset in the middle of a stall
    step(0, 1, 32'h11, 0);
    full_for(3);
    step(1, 0, '0, 1);
    idle(3);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      bit r, v, f;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) < 4);
      step(r, v, $urandom, f);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
